kv_ledger_exec: RTL and testbench

- Execution stage directly downstream of the serial command extractor.
- Accepts one parsed command at a time: opcode, key, destination key and amount.
- Executes the command against an on-chip table of DEPTH key/balance entries.
- Returns a status plus the resulting balance of the primary key (updated_value).

---
 rtl/kv_ledger_pkg.sv | 27 ++
 rtl/kv_ledger_exec_kv_table.sv | 52 +++++
 rtl/kv_ledger_exec.sv | 248 ++++++++++++++++++++++++
 tb/tb_kv_ledger_exec.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kv_ledger_pkg.sv
// Shared opcode/status codes, FSM encoding and default widths for the ledger execution stage.
package kv_ledger_pkg;

  localparam int KEY_W_DEF = 32;
  localparam int VAL_W_DEF = 32;

  localparam logic [2:0] OP_ISSUE    = 3'd1;
  localparam logic [2:0] OP_TRANSFER = 3'd2;
  localparam logic [2:0] OP_REFER    = 3'd3;
  localparam logic [2:0] OP_CREATE   = 3'd4;

  localparam logic [2:0] ST_OK           = 3'd0;
  localparam logic [2:0] ST_NOT_FOUND    = 3'd1;
  localparam logic [2:0] ST_DUPLICATE    = 3'd2;
  localparam logic [2:0] ST_FULL         = 3'd3;
  localparam logic [2:0] ST_INSUFFICIENT = 3'd4;
  localparam logic [2:0] ST_BAD_OP       = 3'd5;
  localparam logic [2:0] ST_OVERFLOW     = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/kv_ledger_exec_kv_table.sv
// DEPTH-entry key/balance register array: one combinational read port, two write ports.
// Port A writes valid+key+balance (create / source update), port B writes balance only (destination credit).
module kv_table #(
  parameter int DEPTH = 8,
  parameter int KEY_W = 32,
  parameter int VAL_W = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_vld_o,
  output logic [KEY_W-1:0] rd_key_o,
  output logic [VAL_W-1:0] rd_bal_o,
  input  logic             wa_en_i,
  input  logic [IDX_W-1:0] wa_idx_i,
  input  logic [KEY_W-1:0] wa_key_i,
  input  logic [VAL_W-1:0] wa_bal_i,
  input  logic             wb_en_i,
  input  logic [IDX_W-1:0] wb_idx_i,
  input  logic [VAL_W-1:0] wb_bal_i
);

  logic [DEPTH-1:0] vld_q;
  logic [KEY_W-1:0] key_q [DEPTH];
  logic [VAL_W-1:0] bal_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= '0;
        bal_q[i] <= '0;
      end
    end else begin
      if (wa_en_i) begin
        vld_q[wa_idx_i] <= 1'b1;
        key_q[wa_idx_i] <= wa_key_i;
        bal_q[wa_idx_i] <= wa_bal_i;
      end
      // The executor never enables both ports on the same index.
      if (wb_en_i) begin
        bal_q[wb_idx_i] <= wb_bal_i;
      end
    end
  end

  assign rd_vld_o = vld_q[rd_idx_i];
  assign rd_key_o = key_q[rd_idx_i];
  assign rd_bal_o = bal_q[rd_idx_i];

endmodule

// File: rtl/kv_ledger_exec.sv
// Ledger command executor: full table scan, one-cycle commit, held response (rsp_valid DEPTH+2 cycles after the accept cycle).
// Optional running supply counter output enabled by defining KV_LEDGER_SUPPLY_EN.
module kv_ledger_exec
  import kv_ledger_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int KEY_W = KEY_W_DEF,
  parameter int VAL_W = VAL_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [KEY_W-1:0] cmd_key,
  input  logic [KEY_W-1:0] cmd_key2,
  input  logic [VAL_W-1:0] cmd_amount,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_status,
  output logic [VAL_W-1:0] updated_value
`ifdef KV_LEDGER_SUPPLY_EN
  ,
  output logic [VAL_W+6:0] total_supply
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [2:0]       rsp_status_q;
  logic [VAL_W-1:0] updated_value_q;

  logic [2:0]       op_q;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] key2_q;
  logic [VAL_W-1:0] amt_q;
  logic [IDX_W-1:0] scan_idx_q;

  logic             src_hit_q, dst_hit_q, free_hit_q;
  logic [IDX_W-1:0] src_idx_q, dst_idx_q, free_idx_q;
  logic [VAL_W-1:0] src_bal_q, dst_bal_q;

  logic             rd_vld;
  logic [KEY_W-1:0] rd_key;
  logic [VAL_W-1:0] rd_bal;

  logic [2:0]       rsp_status_d;
  logic [VAL_W-1:0] updated_value_d;
  logic             wa_en, wb_en, commit_go;
  logic [IDX_W-1:0] wa_idx;
  logic [VAL_W-1:0] wa_bal, wb_bal, src_left;
  logic [VAL_W:0]   iss_sum, dst_sum;

  assign commit_go = (state_q == S_COMMIT);

  kv_table #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W),
    .VAL_W (VAL_W)
  ) u_table (
    .clk_i    (clock),
    .rst_ni   (reset),
    .rd_idx_i (scan_idx_q),
    .rd_vld_o (rd_vld),
    .rd_key_o (rd_key),
    .rd_bal_o (rd_bal),
    .wa_en_i  (wa_en && commit_go),
    .wa_idx_i (wa_idx),
    .wa_key_i (key_q),
    .wa_bal_i (wa_bal),
    .wb_en_i  (wb_en && commit_go),
    .wb_idx_i (dst_idx_q),
    .wb_bal_i (wb_bal)
  );

  // Commit decision from the scan results; only takes effect while in COMMIT.
  always_comb begin
    rsp_status_d    = ST_OK;
    updated_value_d = '0;
    wa_en           = 1'b0;
    wa_idx          = src_idx_q;
    wa_bal          = '0;
    wb_en           = 1'b0;
    wb_bal          = '0;
    iss_sum         = {1'b0, src_bal_q} + {1'b0, amt_q};
    dst_sum         = {1'b0, dst_bal_q} + {1'b0, amt_q};
    src_left        = src_bal_q - amt_q;
    case (op_q)
      OP_CREATE: begin
        if (src_hit_q) begin
          rsp_status_d    = ST_DUPLICATE;
          updated_value_d = src_bal_q;
        end else if (!free_hit_q) begin
          rsp_status_d    = ST_FULL;
        end else begin
          wa_en           = 1'b1;
          wa_idx          = free_idx_q;
          wa_bal          = amt_q;
          updated_value_d = amt_q;
        end
      end
      OP_ISSUE: begin
        if (!src_hit_q) begin
          rsp_status_d    = ST_NOT_FOUND;
        end else if (iss_sum[VAL_W]) begin
          rsp_status_d    = ST_OVERFLOW;
          updated_value_d = src_bal_q;
        end else begin
          wa_en           = 1'b1;
          wa_bal          = iss_sum[VAL_W-1:0];
          updated_value_d = iss_sum[VAL_W-1:0];
        end
      end
      OP_REFER: begin
        if (!src_hit_q) begin
          rsp_status_d    = ST_NOT_FOUND;
        end else begin
          updated_value_d = src_bal_q;
        end
      end
      OP_TRANSFER: begin
        updated_value_d = src_hit_q ? src_bal_q : '0;
        if (!src_hit_q || !dst_hit_q) begin
          rsp_status_d    = ST_NOT_FOUND;
        end else if (src_bal_q < amt_q) begin
          rsp_status_d    = ST_INSUFFICIENT;
        end else if (dst_sum[VAL_W]) begin
          rsp_status_d    = ST_OVERFLOW;
        end else if (key_q != key2_q) begin
          wa_en           = 1'b1;
          wa_bal          = src_left;
          wb_en           = 1'b1;
          wb_bal          = dst_sum[VAL_W-1:0];
          updated_value_d = src_left;
        end
      end
      default: begin
        rsp_status_d    = ST_BAD_OP;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      cmd_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_status_q    <= ST_OK;
      updated_value_q <= '0;
      op_q            <= '0;
      key_q           <= '0;
      key2_q          <= '0;
      amt_q           <= '0;
      scan_idx_q      <= '0;
      src_hit_q       <= 1'b0;
      dst_hit_q       <= 1'b0;
      free_hit_q      <= 1'b0;
      src_idx_q       <= '0;
      dst_idx_q       <= '0;
      free_idx_q      <= '0;
      src_bal_q       <= '0;
      dst_bal_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_op;
            key_q       <= cmd_key;
            key2_q      <= cmd_key2;
            amt_q       <= cmd_amount;
            scan_idx_q  <= '0;
            src_hit_q   <= 1'b0;
            dst_hit_q   <= 1'b0;
            free_hit_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            state_q     <= S_SCAN;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_SCAN: begin
          if (rd_vld && (rd_key == key_q)) begin
            src_hit_q <= 1'b1;
            src_idx_q <= scan_idx_q;
            src_bal_q <= rd_bal;
          end
          if (rd_vld && (rd_key == key2_q)) begin
            dst_hit_q <= 1'b1;
            dst_idx_q <= scan_idx_q;
            dst_bal_q <= rd_bal;
          end
          // Ascending scan: the first free slot seen is the lowest one.
          if (!rd_vld && !free_hit_q) begin
            free_hit_q <= 1'b1;
            free_idx_q <= scan_idx_q;
          end
          if (scan_idx_q == LAST_IDX) begin
            state_q <= S_COMMIT;
          end else begin
            scan_idx_q <= scan_idx_q + IDX_W'(1);
          end
        end
        S_COMMIT: begin
          rsp_status_q    <= rsp_status_d;
          updated_value_q <= updated_value_d;
          rsp_valid_q     <= 1'b1;
          state_q         <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = rsp_status_q;
  assign updated_value = updated_value_q;

`ifdef KV_LEDGER_SUPPLY_EN
  logic [VAL_W+6:0] total_supply_q;

  // Transfers move value between entries, so only minting ops change the sum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      total_supply_q <= '0;
    end else if (commit_go && (rsp_status_d == ST_OK) &&
                 ((op_q == OP_CREATE) || (op_q == OP_ISSUE))) begin
      total_supply_q <= total_supply_q + {7'd0, amt_q};
    end
  end

  assign total_supply = total_supply_q;
`endif

endmodule

// File: tb/tb_kv_ledger_exec.sv
// Randomized self-checking bench for kv_ledger_exec against an array-based ledger model.
module tb_kv_ledger_exec;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_key;
  logic [31:0] cmd_key2;
  logic [31:0] cmd_amount;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_status;
  logic [31:0] updated_value;
`ifdef KV_LEDGER_SUPPLY_EN
  logic [38:0] total_supply;
`endif

  always #5 clock = ~clock;

  kv_ledger_exec #(.DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_key       (cmd_key),
    .cmd_key2      (cmd_key2),
    .cmd_amount    (cmd_amount),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_status    (rsp_status),
    .updated_value (updated_value)
`ifdef KV_LEDGER_SUPPLY_EN
    ,
    .total_supply  (total_supply)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ledger: plain arrays, searched by key.
  bit          m_vld [DEPTH];
  bit [31:0]   m_key [DEPTH];
  bit [31:0]   m_bal [DEPTH];
  longint      m_supply;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 1'b0;
      m_key[i] = '0;
      m_bal[i] = '0;
    end
    m_supply = 0;
  endtask

  function automatic int find(input bit [31:0] k);
    for (int i = 0; i < DEPTH; i++)
      if (m_vld[i] && m_key[i] == k) return i;
    return -1;
  endfunction

  task automatic model_exec(input bit [2:0] op, input bit [31:0] k, input bit [31:0] k2,
                            input bit [31:0] amt, output bit [2:0] st, output bit [31:0] val);
    int s, d, f;
    longint maxv;
    maxv = 64'hFFFF_FFFF;
    s = find(k);
    d = find(k2);
    f = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_vld[i]) f = i;
    st = 3'd0;
    val = '0;
    case (op)
      3'd4: begin
        if (s >= 0) begin st = 3'd2; val = m_bal[s]; end
        else if (f < 0) st = 3'd3;
        else begin
          m_vld[f] = 1'b1; m_key[f] = k; m_bal[f] = amt;
          val = amt; m_supply += longint'(amt);
        end
      end
      3'd1: begin
        if (s < 0) st = 3'd1;
        else if (longint'(m_bal[s]) + longint'(amt) > maxv) begin st = 3'd6; val = m_bal[s]; end
        else begin m_bal[s] += amt; val = m_bal[s]; m_supply += longint'(amt); end
      end
      3'd3: begin
        if (s < 0) st = 3'd1;
        else val = m_bal[s];
      end
      3'd2: begin
        if (s >= 0) val = m_bal[s];
        if (s < 0 || d < 0) st = 3'd1;
        else if (m_bal[s] < amt) st = 3'd4;
        else if (longint'(m_bal[d]) + longint'(amt) > maxv) st = 3'd6;
        else if (k != k2) begin
          m_bal[s] -= amt; m_bal[d] += amt; val = m_bal[s];
        end
      end
      default: st = 3'd5;
    endcase
  endtask

  task automatic do_cmd(input bit [2:0] op, input bit [31:0] k, input bit [31:0] k2,
                        input bit [31:0] amt, input int hold);
    bit [2:0]    exp_st;
    bit [31:0]   exp_v;
    logic [2:0]  s0;
    logic [31:0] v0;
    int          n;
    model_exec(op, k, k2, amt, exp_st, exp_v);
    @(negedge clock);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_key    = k;
    cmd_key2   = k2;
    cmd_amount = amt;
    rsp_ready  = (hold == 0);
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    cmd_valid  = 1'b0;
    cmd_op     = 3'($urandom_range(0, 7));
    cmd_key    = $urandom;
    cmd_key2   = $urandom;
    cmd_amount = $urandom;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!rsp_valid && n < 4 * DEPTH + 20);
    if (!rsp_valid) begin
      check("rsp_timeout", 64'(rsp_valid), 64'(1));
      return;
    end
    check("latency", 64'(n), 64'(DEPTH + 2));
    s0 = rsp_status;
    v0 = updated_value;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_valid", 64'(rsp_valid), 64'(1));
      check("hold_status", 64'(rsp_status), 64'(s0));
      check("hold_value", 64'(updated_value), 64'(v0));
      check("hold_cmd_ready", 64'(cmd_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    check($sformatf("status op%0d", op), 64'(s0), 64'(exp_st));
    check($sformatf("value op%0d", op), 64'(v0), 64'(exp_v));
    @(negedge clock);
    rsp_ready = 1'b0;
    check("rsp_drop", 64'(rsp_valid), 64'(0));
    check("idle_ready", 64'(cmd_ready), 64'(1));
`ifdef KV_LEDGER_SUPPLY_EN
    check("supply", 64'(total_supply), 64'(m_supply));
`endif
  endtask

  bit [31:0] pool [10];

  initial begin
    bit [2:0]  rop;
    bit [31:0] ramt;
    int        seen;
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_key    = '0;
    cmd_key2   = '0;
    cmd_amount = '0;
    rsp_ready  = 1'b0;
    model_clear();
    for (int i = 0; i < 10; i++) pool[i] = 32'h500 + 32'(i * 7);

    @(negedge clock);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_status", 64'(rsp_status), 64'(0));
    check("rst_value", 64'(updated_value), 64'(0));
    @(negedge clock);
    reset = 1'b1;

    do_cmd(3'd4, 32'h0000_020C, 0, 100, 0);
    do_cmd(3'd4, 32'h0000_020C, 0, 55, 0);
    do_cmd(3'd4, 32'h0000_0117, 0, 100, 0);
    do_cmd(3'd1, 32'h0000_0117, 0, 100, 0);
    do_cmd(3'd3, 32'h0000_0117, 0, 0, 0);
    do_cmd(3'd3, 32'h0000_0999, 0, 0, 0);
    do_cmd(3'd2, 32'h0000_0117, 32'h0000_0013, 100, 0);
    do_cmd(3'd3, 32'h0000_0117, 0, 0, 0);
    do_cmd(3'd4, 32'h0000_0013, 0, 0, 0);
    do_cmd(3'd2, 32'h0000_0117, 32'h0000_0013, 100, 0);
    do_cmd(3'd3, 32'h0000_0013, 0, 0, 0);
    do_cmd(3'd2, 32'h0000_0117, 32'h0000_0013, 101, 0);
    do_cmd(3'd2, 32'h0000_0013, 32'h0000_0013, 40, 0);
    for (int i = 0; i < DEPTH - 4; i++) do_cmd(3'd4, 32'h1000 + 32'(i), 0, 32'(i * 3), 0);
    do_cmd(3'd4, 32'h0000_2000, 0, 32'hFFFF_FFF0, 0);
    do_cmd(3'd4, 32'h0000_3000, 0, 5, 0);
    do_cmd(3'd1, 32'h0000_2000, 0, 32'h20, 0);
    do_cmd(3'd1, 32'h0000_2000, 0, 32'hF, 0);
    do_cmd(3'd2, 32'h0000_020C, 32'h0000_2000, 1, 0);
    do_cmd(3'd7, 32'h0000_020C, 0, 1, 0);
    do_cmd(3'd0, 32'h0000_020C, 0, 1, 0);
    do_cmd(3'd3, 32'h0000_020C, 0, 0, 10);

    // Reset while the command is still scanning.
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = 3'd3;
    cmd_key   = 32'h0000_0117;
    seen = 0;
    while (!cmd_ready && seen < 50) begin
      @(negedge clock);
      seen++;
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_status", 64'(rsp_status), 64'(0));
    check("midrst_value", 64'(updated_value), 64'(0));
    model_clear();
    @(negedge clock);
    reset     = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < DEPTH + 6; i++) begin
      @(negedge clock);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    check("midrst_no_rsp", 64'(seen), 64'(0));
    do_cmd(3'd3, 32'h0000_0117, 0, 0, 0);

    do_cmd(3'd4, 32'h0000_000A, 0, 100, 0);
    do_cmd(3'd1, 32'h0000_000A, 0, 50, 0);
    do_cmd(3'd4, 32'h0000_000B, 0, 0, 0);
    do_cmd(3'd2, 32'h0000_000A, 32'h0000_000B, 30, 0);

    for (int it = 0; it < 90; it++) begin
      case ($urandom_range(0, 3))
        0: ramt = 0;
        1: ramt = 32'($urandom_range(1, 200));
        2: ramt = $urandom;
        default: ramt = 32'hFFFF_FFFF - 32'($urandom_range(0, 300));
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2: rop = 3'd4;
        3, 4:    rop = 3'd1;
        5, 6:    rop = 3'd2;
        7, 8:    rop = 3'd3;
        default: rop = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'(5 + $urandom_range(0, 2));
      endcase
      do_cmd(rop, pool[$urandom_range(0, 9)], pool[$urandom_range(0, 9)], ramt,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
